elastic_pipe_reg: RTL and testbench

Parametrised, elastic successor to the fixed stall/flush pipeline latches between the PC/IF/ID/EX/MEM/WB stages. Each instance holds one pipeline stage's payload behind a valid/ready handshake, so back-pressure propagates one stage per cycle without a global stall net. A 2-entry skid buffer keeps full throughput under back-pressure. Flush inserts a bubble with cleared control fields, and a global freeze (cache miss, halt) holds all state. Saturating stall and bubble counters support pipeline performance analysis.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/sat_counter.sv | 20 ++
 rtl/elastic_pipe_reg.sv | 122 ++++++++++++
 tb/tb_elastic_pipe_reg.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register and its helpers.
package pipe_pkg;

    localparam int WORD_SIZE   = 16;
    localparam int PIPE_CTRL_W = 8;

    // Encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, never wrapping past the maximum value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline stage register with a 2-entry skid buffer, flush, freeze
// and saturating stall/bubble performance counters.
//
// state    | meaning
// ST_EMPTY | no entry held, output bubble
// ST_FULL  | main entry presented downstream
// ST_SKID  | main presented, one more parked in skid; input closed
module elastic_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = WORD_SIZE,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              freeze,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    state_t            state, state_nxt;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_nxt, skid_ctrl, skid_ctrl_nxt;
    logic [DATA_W-1:0] main_data, main_data_nxt, skid_data, skid_data_nxt;
    logic              in_xfer, out_xfer;

    // Ready depends only on registered state plus the global controls.
    assign in_ready  = !freeze && !flush && (state != ST_SKID);
    assign out_valid = (state != ST_EMPTY);
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occupancy = state;

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready && !freeze;

    // Register update; reset overrides flush and freeze.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            state     <= state_nxt;
            main_ctrl <= main_ctrl_nxt;
            main_data <= main_data_nxt;
            skid_ctrl <= skid_ctrl_nxt;
            skid_data <= skid_data_nxt;
        end
    end

    // Next state and payload; flush wins over freeze, data regs survive a flush.
    always_comb begin
        state_nxt     = state;
        main_ctrl_nxt = main_ctrl;
        main_data_nxt = main_data;
        skid_ctrl_nxt = skid_ctrl;
        skid_data_nxt = skid_data;
        if (flush) begin
            state_nxt     = ST_EMPTY;
            main_ctrl_nxt = '0;
            skid_ctrl_nxt = '0;
        end else if (!freeze) begin
            unique case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_nxt     = ST_FULL;
                        main_ctrl_nxt = in_ctrl;
                        main_data_nxt = in_data;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_ctrl_nxt = in_ctrl;
                        main_data_nxt = in_data;
                    end else if (in_xfer) begin
                        state_nxt     = ST_SKID;
                        skid_ctrl_nxt = in_ctrl;
                        skid_data_nxt = in_data;
                    end else if (out_xfer) begin
                        state_nxt     = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_xfer) begin
                        state_nxt     = ST_FULL;
                        main_ctrl_nxt = skid_ctrl;
                        main_data_nxt = skid_data;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (out_valid && !out_ready && !freeze),
        .count   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (!out_valid && !freeze),
        .count   (bubble_cnt)
    );

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based model of the stage.
module tb_elastic_pipe_reg;

    localparam int DW = 16;
    localparam int CW = 8;
    localparam int NW = 4;
    localparam int CMAX = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          reset_n, in_valid, in_ready, out_valid, out_ready, flush, freeze;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occupancy;
    logic [NW-1:0] stall_cnt, bubble_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model: FIFO of {ctrl,data}, capacity 2.
    logic [CW+DW-1:0] mq[$];
    logic [DW-1:0]    m_last_data;
    int               m_stall, m_bubble;
    bit               m_known = 0;

    elastic_pipe_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_data   (out_data),
        .flush      (flush),
        .freeze     (freeze),
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [31:0] exp_ctrl;
        exp_ctrl = (mq.size() > 0) ? 32'(mq[0][CW+DW-1:DW]) : 32'd0;
        check("occupancy", 32'(occupancy), 32'(mq.size()));
        check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        check("out_ctrl",  32'(out_ctrl), exp_ctrl);
        check("out_data",  32'(out_data), 32'(m_last_data));
        check("in_ready",  32'(in_ready), 32'(!freeze && !flush && mq.size() < 2));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("bubble_cnt", 32'(bubble_cnt), 32'(m_bubble));
    endtask

    task automatic model_edge();
        bit ov, ix, ox;
        if (!reset_n) begin
            mq.delete();
            m_last_data = '0;
            m_stall = 0;
            m_bubble = 0;
            m_known = 1;
            return;
        end
        ov = mq.size() > 0;
        ix = in_valid && !freeze && !flush && mq.size() < 2;
        ox = ov && out_ready && !freeze;
        if (!freeze) begin
            if (ov && !out_ready && m_stall < CMAX) m_stall++;
            if (!ov && m_bubble < CMAX) m_bubble++;
        end
        if (flush) mq.delete();
        else if (!freeze) begin
            if (ox) void'(mq.pop_front());
            if (ix) mq.push_back({in_ctrl, in_data});
        end
        if (mq.size() > 0) m_last_data = mq[0][DW-1:0];
    endtask

    // One clock: check pre-edge outputs, clock, update model, land on negedge.
    task automatic cyc();
        #1;
        if (m_known && reset_n) compare_model();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic ordy, input logic fl, input logic fz);
        in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl; freeze = fz;
        cyc();
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_occupancy", 32'(occupancy), 0);
        reset_n = 1'b1;

        // Stream 1..5 at full throughput.
        for (int i = 1; i <= 5; i++) drive(1, 8'(i), 16'(i), 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);

        // Back-pressure into the skid entry, then drain.
        drive(1, 8'h11, 16'h00A0, 0, 0, 0);
        drive(1, 8'h12, 16'h00A1, 0, 0, 0);
        drive(1, 8'h13, 16'h00A2, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);

        // Flush while in SKID with an offered input.
        drive(1, 8'h21, 16'h00B0, 0, 0, 0);
        drive(1, 8'h22, 16'h00B1, 0, 0, 0);
        drive(1, 8'hFF, 16'h00BF, 0, 1, 0);
        #1;
        check("flush_occupancy", 32'(occupancy), 0);
        check("flush_out_ctrl", 32'(out_ctrl), 0);
        drive(0, 0, 0, 1, 0, 0);

        // Freeze three cycles in FULL with downstream ready.
        drive(1, 8'h31, 16'h00C0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 1);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);

        // Flush and freeze together in FULL.
        drive(1, 8'h41, 16'h00D0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0);

        // Reset mid-SKID.
        drive(1, 8'h51, 16'h00E0, 0, 0, 0);
        drive(1, 8'h52, 16'h00E1, 0, 0, 0);
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("rst_skid_occ", 32'(occupancy), 0);
        check("rst_skid_data", 32'(out_data), 0);
        check("rst_skid_stall", 32'(stall_cnt), 0);
        check("rst_skid_bubble", 32'(bubble_cnt), 0);
        reset_n = 1'b1;

        // Saturation of both counters.
        drive(1, 8'h61, 16'h00F0, 0, 0, 0);
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 0);
        #1;
        check("stall_sat", 32'(stall_cnt), CMAX);
        drive(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 0);
        #1;
        check("bubble_sat", 32'(bubble_cnt), CMAX);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 2) != 0, 8'($urandom), 16'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 7) == 0);
        end
        reset_n = 1'b1;
        drive(0, 0, 0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
